// File: rtl/asp_pkg.sv
// ---------------------------------------------------------------------------
// asp_pkg -- shared definitions for the stage_3 network/host queueing stage.
//
// Contents:
//   opcode_e   : stage-2 opcode encoding (NOP, TX, RX, TAGCLR)
//   ERR_CNT_W  : width of the saturating error event counters
//   sat_inc()  : saturating increment used by the event counters
// ---------------------------------------------------------------------------
package asp_pkg;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_TX     = 2'b01,
        OP_RX     = 2'b10,
        OP_TAGCLR = 2'b11
    } opcode_e;

    localparam int ERR_CNT_W = 16;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] value,
                                                     input logic                 event_hit);
        if (event_hit && (value != {ERR_CNT_W{1'b1}}))
            sat_inc = value + ERR_CNT_W'(1);
        else
            sat_inc = value;
    endfunction

endpackage

// File: rtl/stage_3_fifo.sv
// ---------------------------------------------------------------------------
// stage_3_fifo -- small synchronous FIFO used for both stage_3 queues.
//
// Parameters:
//   width : entry width in bits
//   depth : number of entries (power of two, >= 2)
//
// Ports:
//   clk, reset     : clock, synchronous active-high reset (empties the queue)
//   push, push_data: write request and data; ignored when full unless a pop
//                    happens in the same cycle
//   full           : queue holds depth entries
//   pop            : read request; ignored when empty
//   pop_data       : head entry, forced to 0 while the queue is empty
//   empty          : queue holds no entries
//   count          : current occupancy (0..depth)
// ---------------------------------------------------------------------------
module stage_3_fifo
    import asp_pkg::*;
#(
    parameter int width = 32,
    parameter int depth = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [width-1:0]       push_data,
    output logic                   full,
    input  logic                   pop,
    output logic [width-1:0]       pop_data,
    output logic                   empty,
    output logic [$clog2(depth):0] count
);

    localparam int PW = $clog2(depth);
    localparam int CW = PW + 1;

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(depth));
    assign count    = count_q;
    // Memory is not reset, so the head is masked to keep outputs at 0 when empty.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // A push into a full queue is only allowed when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            // Power-of-two depth lets the pointer wrap naturally.
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/stage_3.sv
// ---------------------------------------------------------------------------
// stage_3 -- tags outgoing host data, checks tags on incoming network data,
// and buffers both directions in small FIFOs with valid/ready handshakes.
//
// Parameters:
//   data_size  : payload width
//   tag_size   : network tag width
//   fifo_depth : entries per queue (power of two, >= 2)
//
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   opcode_in          : 00 NOP, 01 TX, 10 RX, 11 TAGCLR (sampled every cycle)
//   soft_error_in      : host-data parity failure, only meaningful with TX
//   tx_data            : host payload for TX
//   rx_data, rx_tag    : network payload and tag for RX
//   net_out            : {payload, tag} toward the network, tag in low bits
//   net_valid/ready    : network-side handshake
//   host_out           : tag-checked payload toward the host
//   host_valid/ready   : host-side handshake
//   tag_error          : one-cycle pulse after an RX tag mismatch
//   overflow           : sticky, set when a push is dropped on a full queue
//   soft_error_count   : saturating count of TX soft errors
//   tag_error_count    : saturating count of RX tag mismatches
//
// Configuration:
//   STAGE3_ERR_COUNT_EN : when defined, the two event counters are built;
//                         otherwise both counter ports are tied to 0.
// ---------------------------------------------------------------------------
module stage_3
    import asp_pkg::*;
#(
    parameter int data_size  = 32,
    parameter int tag_size   = 8,
    parameter int fifo_depth = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    opcode_in,
    input  logic                          soft_error_in,
    input  logic [data_size-1:0]          tx_data,
    input  logic [data_size-1:0]          rx_data,
    input  logic [tag_size-1:0]           rx_tag,
    output logic [data_size+tag_size-1:0] net_out,
    output logic                          net_valid,
    input  logic                          net_ready,
    output logic [data_size-1:0]          host_out,
    output logic                          host_valid,
    input  logic                          host_ready,
    output logic                          tag_error,
    output logic                          overflow,
    output logic [ERR_CNT_W-1:0]          soft_error_count,
    output logic [ERR_CNT_W-1:0]          tag_error_count
);

    localparam int CNT_BITS = $clog2(fifo_depth) + 1;

    logic [tag_size-1:0] tx_seq_q, tx_seq_d;
    logic [tag_size-1:0] rx_exp_q, rx_exp_d;
    logic                tag_error_q, tag_error_d;
    logic                overflow_q, overflow_d;

    logic                          tx_push, tx_full, tx_empty;
    logic                          rx_push, rx_full, rx_empty;
    logic [data_size+tag_size-1:0] tx_push_data;
    logic [CNT_BITS-1:0]           tx_count, rx_count;

    // The tag travels with the payload, so it is latched into the queue entry.
    assign tx_push_data = {tx_data, tx_seq_q};

    // Opcode decode: sequence/expected-tag updates and push requests.
    // Sequence numbers advance on every accepted opcode even if the queue drops it.
    always_comb begin
        tx_push     = 1'b0;
        rx_push     = 1'b0;
        tx_seq_d    = tx_seq_q;
        rx_exp_d    = rx_exp_q;
        tag_error_d = 1'b0;
        overflow_d  = overflow_q;
        if (opcode_in == OP_TX) begin
            if (!soft_error_in) begin
                tx_push  = 1'b1;
                tx_seq_d = tx_seq_q + tag_size'(1);
            end
        end else if (opcode_in == OP_RX) begin
            if (rx_tag == rx_exp_q) begin
                rx_push  = 1'b1;
                rx_exp_d = rx_exp_q + tag_size'(1);
            end else begin
                tag_error_d = 1'b1;
            end
        end else if (opcode_in == OP_TAGCLR) begin
            tx_seq_d = '0;
            rx_exp_d = '0;
        end
        // A full queue is never empty, so ready alone means the head leaves this cycle.
        if ((tx_push && tx_full && !net_ready) || (rx_push && rx_full && !host_ready)) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_seq_q    <= '0;
            rx_exp_q    <= '0;
            tag_error_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            tx_seq_q    <= tx_seq_d;
            rx_exp_q    <= rx_exp_d;
            tag_error_q <= tag_error_d;
            overflow_q  <= overflow_d;
        end
    end

    stage_3_fifo #(
        .width (data_size + tag_size),
        .depth (fifo_depth)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (tx_push_data),
        .full      (tx_full),
        .pop       (net_ready),
        .pop_data  (net_out),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    stage_3_fifo #(
        .width (data_size),
        .depth (fifo_depth)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_data),
        .full      (rx_full),
        .pop       (host_ready),
        .pop_data  (host_out),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    // Occupancy and full flag must always agree; catches a broken queue early in simulation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (tx_full == (tx_count == CNT_BITS'(fifo_depth)));
            assert (rx_full == (rx_count == CNT_BITS'(fifo_depth)));
        end
    end

    assign net_valid  = !tx_empty;
    assign host_valid = !rx_empty;
    assign tag_error  = tag_error_q;
    assign overflow   = overflow_q;

`ifdef STAGE3_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] soft_cnt_q, soft_cnt_d;
    logic [ERR_CNT_W-1:0] tag_cnt_q, tag_cnt_d;

    // Event counters: soft errors only count on TX, tag errors on RX mismatch.
    always_comb begin
        soft_cnt_d = sat_inc(soft_cnt_q, (opcode_in == OP_TX) && soft_error_in);
        tag_cnt_d  = sat_inc(tag_cnt_q, tag_error_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            soft_cnt_q <= '0;
            tag_cnt_q  <= '0;
        end else begin
            soft_cnt_q <= soft_cnt_d;
            tag_cnt_q  <= tag_cnt_d;
        end
    end

    assign soft_error_count = soft_cnt_q;
    assign tag_error_count  = tag_cnt_q;
`else
    assign soft_error_count = '0;
    assign tag_error_count  = '0;
`endif

endmodule
